// File: rtl/instr_encoder_if.sv
// instr_encoder_if
// Groups the field-bundle handshake, the instruction-memory write port and
// the loader status flags of the instruction encoder.
//   master : bundle producer / memory side (drives fields, in_valid, mem_ready)
//   slave  : the encoder (drives in_ready, imem_*, wr_count and status flags)
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        in_cond;
    logic [1:0]        in_op;
    logic [5:0]        in_funct;
    logic [3:0]        in_rn;
    logic [3:0]        in_rd;
    logic [11:0]       in_src2;
    logic [23:0]       in_imm24;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;
    logic              mem_ready;
    logic [ADDR_W:0]   wr_count;
    logic              done;
    logic              full;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output in_valid, in_last, in_cond, in_op, in_funct, in_rn, in_rd,
               in_src2, in_imm24, mem_ready,
        input  in_ready, imem_we, imem_addr, imem_wd, wr_count, done, full,
               err, err_code
    );

    modport slave (
        input  in_valid, in_last, in_cond, in_op, in_funct, in_rn, in_rd,
               in_src2, in_imm24, mem_ready,
        output in_ready, imem_we, imem_addr, imem_wd, wr_count, done, full,
               err, err_code
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder
// Program loader: accepts instruction field bundles, rejects combinations the
// decoder does not support, packs legal ones into 32-bit words and writes them
// to consecutive instruction-memory words starting at BASE_ADDR.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - instr_encoder_if.slave: field bundle handshake (in_*), memory write
//           port (imem_we/imem_addr/imem_wd, mem_ready) and status
//           (wr_count, done, full, err, err_code)
module instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            reset,
    instr_encoder_if.slave  bus
);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
    // Last word of the window; equals BASE_A + 2**ADDR_W - 1 modulo the width.
    localparam logic [ADDR_W-1:0] LAST_A = BASE_A - ONE_A;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wd_q, imem_wd_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              in_ready_s;
    logic              accept_s;
    logic              drop_full_s;
    logic              wr_done_s;
    logic [1:0]        chk_code_s;
    logic [31:0]       word_s;

    // Legality of an op/funct pair: 00 legal, 01 bad op, 10 bad funct.
    function automatic logic [1:0] field_check(input logic [1:0] op,
                                               input logic [5:0] funct);
        logic [1:0] code;
        code = 2'b00;
        case (op)
            2'b00: begin
                case (funct[4:1])
                    4'b0100, 4'b0010, 4'b0000, 4'b1100: code = 2'b00;
                    // Compare-class commands only exist with S set.
                    4'b1000, 4'b1001, 4'b1010: code = funct[0] ? 2'b00 : 2'b10;
                    default: code = 2'b10;
                endcase
            end
            2'b01:   code = (funct[4] & ~funct[2] & ~funct[1]) ? 2'b00 : 2'b10;
            2'b10:   code = funct[5] ? 2'b00 : 2'b10;
            default: code = 2'b01;
        endcase
        return code;
    endfunction

    // Packs the fields into the machine-word layout for the given op.
    function automatic logic [31:0] encode_word(input logic [3:0]  cond,
                                                input logic [1:0]  op,
                                                input logic [5:0]  funct,
                                                input logic [3:0]  rn,
                                                input logic [3:0]  rd,
                                                input logic [11:0] src2,
                                                input logic [23:0] imm24);
        logic [31:0] w;
        case (op)
            2'b10:   w = {cond, 2'b10, funct[5:4], imm24};
            default: w = {cond, op, funct, rn, rd, src2};
        endcase
        return w;
    endfunction

    // Handshake and event decode (FSM output logic).
    always_comb begin
        in_ready_s  = (state_q == ST_IDLE) & ~done_q & ~full_q;
        accept_s    = bus.in_valid & in_ready_s;
        // A full loader reports the dropped bundle unless done already masks input.
        drop_full_s = bus.in_valid & (state_q == ST_IDLE) & full_q & ~done_q;
        wr_done_s   = (state_q == ST_WRITE) & bus.mem_ready;
        chk_code_s  = field_check(bus.in_op, bus.in_funct);
        word_s      = encode_word(bus.in_cond, bus.in_op, bus.in_funct, bus.in_rn,
                                  bus.in_rd, bus.in_src2, bus.in_imm24);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (chk_code_s == 2'b00)) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (bus.mem_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and status next values.
    always_comb begin
        imem_we_d   = imem_we_q;
        imem_addr_d = imem_addr_q;
        imem_wd_d   = imem_wd_q;
        wr_count_d  = wr_count_q;
        last_d      = last_q;
        done_d      = done_q;
        full_d      = full_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        if (accept_s) begin
            if (chk_code_s == 2'b00) begin
                imem_we_d = 1'b1;
                imem_wd_d = word_s;
                last_d    = bus.in_last;
            end else begin
                err_d      = 1'b1;
                err_code_d = err_q ? err_code_q : chk_code_s;
                done_d     = done_q | bus.in_last;
            end
        end else if (drop_full_s) begin
            err_d      = 1'b1;
            err_code_d = err_q ? err_code_q : 2'b11;
        end else if (wr_done_s) begin
            imem_we_d  = 1'b0;
            wr_count_d = wr_count_q + {{ADDR_W{1'b0}}, 1'b1};
            done_d     = done_q | last_q;
            if (imem_addr_q == LAST_A) begin
                full_d      = 1'b1;
                imem_addr_d = BASE_A;
            end else begin
                imem_addr_d = imem_addr_q + ONE_A;
            end
        end else begin
            imem_we_d = imem_we_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            imem_we_q   <= 1'b0;
            imem_addr_q <= BASE_A;
            imem_wd_q   <= 32'h0000_0000;
            wr_count_q  <= {(ADDR_W+1){1'b0}};
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_wd_q   <= imem_wd_d;
            wr_count_q  <= wr_count_d;
            last_q      <= last_d;
            done_q      <= done_d;
            full_q      <= full_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.imem_we   = imem_we_q;
    assign bus.imem_addr = imem_addr_q;
    assign bus.imem_wd   = imem_wd_q;
    assign bus.wr_count  = wr_count_q;
    assign bus.done      = done_q;
    assign bus.full      = full_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized bundles checked
// against an arithmetic reference model. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_instr_encoder;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    instr_encoder_if #(.ADDR_W(6)) ifa ();
    instr_encoder_if #(.ADDR_W(2)) ifb ();

    instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    always #5 clk = ~clk;

    // Reference legality: 0 legal, 1 bad op, 2 bad funct.
    function automatic int ref_code(input int op, input int funct);
        int cmd;
        cmd = (funct / 2) % 16;
        if (op == 3) return 1;
        if (op == 0) begin
            if (!(cmd inside {4, 2, 0, 12, 8, 9, 10})) return 2;
            if ((cmd inside {8, 9, 10}) && (funct % 2 == 0)) return 2;
            return 0;
        end
        if (op == 1) return (((funct / 16) % 2 == 1) && ((funct / 4) % 2 == 0) && ((funct / 2) % 2 == 0)) ? 0 : 2;
        return (funct >= 32) ? 0 : 2;
    endfunction

    // Reference machine word built with plain arithmetic.
    function automatic logic [31:0] ref_word(input int cond, input int op, input int funct,
                                             input int rn, input int rd, input int src2, input int imm24);
        longint w;
        if (op == 2)
            w = longint'(cond) * 268435456 + 2 * 67108864 + longint'(funct / 16) * 16777216 + imm24;
        else
            w = longint'(cond) * 268435456 + longint'(op) * 67108864 + longint'(funct) * 1048576
                + rn * 65536 + rd * 4096 + src2;
        return w[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifa.in_valid = 1'b0; ifa.mem_ready = 1'b0; ifa.in_last = 1'b0;
        ifb.in_valid = 1'b0; ifb.mem_ready = 1'b0; ifb.in_last = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Presents one bundle on DUT A with in_valid high (stimulus only).
    task automatic drive_a(input int cond, input int op, input int funct, input int rn,
                           input int rd, input int src2, input int imm24, input logic last);
        ifa.in_cond = 4'(cond); ifa.in_op = 2'(op); ifa.in_funct = 6'(funct);
        ifa.in_rn = 4'(rn); ifa.in_rd = 4'(rd); ifa.in_src2 = 12'(src2);
        ifa.in_imm24 = 24'(imm24); ifa.in_last = last; ifa.in_valid = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (ifa.imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%0b exp=0", ifa.imem_we); end
        n_cmp++; if (ifa.imem_addr !== 6'd0) begin n_fail++; $display("FAIL rst_addr got=%0d exp=0", ifa.imem_addr); end
        n_cmp++; if (ifa.imem_wd !== 32'h0) begin n_fail++; $display("FAIL rst_wd got=%h exp=0", ifa.imem_wd); end
        n_cmp++; if (ifa.wr_count !== 7'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", ifa.wr_count); end
        n_cmp++; if ({ifa.done, ifa.full, ifa.err, ifa.err_code} !== 5'b00000) begin n_fail++;
            $display("FAIL rst_flags got=%b exp=00000", {ifa.done, ifa.full, ifa.err, ifa.err_code}); end
        n_cmp++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%0b exp=1", ifa.in_ready); end
    endtask

    task automatic test_dp_add();
        drive_a(14, 0, 6'b101000, 2, 1, 12'h005, 0, 1'b0);
        ifa.mem_ready = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
        n_cmp++; if (ifa.imem_we !== 1'b1) begin n_fail++; $display("FAIL add_we got=%0b exp=1", ifa.imem_we); end
        n_cmp++; if (ifa.imem_addr !== 6'd0) begin n_fail++; $display("FAIL add_addr got=%0d exp=0", ifa.imem_addr); end
        n_cmp++; if (ifa.imem_wd !== 32'hE282_1005) begin n_fail++; $display("FAIL add_wd got=%h exp=E2821005", ifa.imem_wd); end
        tick();
        ifa.mem_ready = 1'b0;
        n_cmp++; if (ifa.wr_count !== 7'd1) begin n_fail++; $display("FAIL add_cnt got=%0d exp=1", ifa.wr_count); end
        n_cmp++; if (ifa.imem_addr !== 6'd1) begin n_fail++; $display("FAIL add_addr_inc got=%0d exp=1", ifa.imem_addr); end
        n_cmp++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready got=%0b exp=1", ifa.in_ready); end
        n_cmp++; if (ifa.imem_we !== 1'b0) begin n_fail++; $display("FAIL add_we_off got=%0b exp=0", ifa.imem_we); end
    endtask

    task automatic test_ldr_stall();
        drive_a(14, 1, 6'b011001, 0, 3, 12'h004, 0, 1'b0);
        ifa.mem_ready = 1'b0;
        tick();
        ifa.in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (ifa.imem_we !== 1'b1 || ifa.imem_wd !== 32'hE590_3004 || ifa.imem_addr !== 6'd1) begin n_fail++;
                $display("FAIL ldr_hold c=%0d got we=%0b wd=%h addr=%0d exp we=1 wd=E5903004 addr=1", c, ifa.imem_we, ifa.imem_wd, ifa.imem_addr); end
            n_cmp++; if (ifa.in_ready !== 1'b0 || ifa.wr_count !== 7'd1) begin n_fail++;
                $display("FAIL ldr_busy c=%0d got ready=%0b cnt=%0d exp ready=0 cnt=1", c, ifa.in_ready, ifa.wr_count); end
            if (c == 3) ifa.mem_ready = 1'b1;
            tick();
        end
        ifa.mem_ready = 1'b0;
        n_cmp++; if (ifa.imem_we !== 1'b0 || ifa.wr_count !== 7'd2 || ifa.imem_addr !== 6'd2) begin n_fail++;
            $display("FAIL ldr_done got we=%0b cnt=%0d addr=%0d exp we=0 cnt=2 addr=2", ifa.imem_we, ifa.wr_count, ifa.imem_addr); end
    endtask

    // Randomized bundles against the reference model; continues from two written words.
    task automatic test_random();
        int m_addr, m_count, m_code, r_cond, r_op, r_funct, r_rn, r_rd, r_src2, r_imm, code, stall;
        int dp_cmd[7] = '{4, 2, 0, 12, 8, 9, 10};
        logic m_err;
        logic [31:0] exp_w;
        m_addr = 2; m_count = 2; m_err = 1'b0; m_code = 0;
        for (int i = 0; i < 40; i++) begin
            r_cond = $urandom_range(0, 15);
            r_op = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            r_funct = $urandom_range(0, 63);
            if (r_op == 0 && $urandom_range(0, 1) == 1)
                r_funct = $urandom_range(0, 1) * 32 + dp_cmd[$urandom_range(0, 6)] * 2 + $urandom_range(0, 1);
            r_rn = $urandom_range(0, 15); r_rd = $urandom_range(0, 15);
            r_src2 = $urandom_range(0, 4095); r_imm = $urandom_range(0, 16777215);
            code = ref_code(r_op, r_funct);
            exp_w = ref_word(r_cond, r_op, r_funct, r_rn, r_rd, r_src2, r_imm);
            drive_a(r_cond, r_op, r_funct, r_rn, r_rd, r_src2, r_imm, 1'b0);
            ifa.mem_ready = 1'($urandom_range(0, 1));
            n_cmp++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready i=%0d got=%0b exp=1", i, ifa.in_ready); end
            tick();
            ifa.in_valid = 1'b0;
            if (code == 0) begin
                n_cmp++; if (ifa.imem_we !== 1'b1 || ifa.imem_addr !== 6'(m_addr) || ifa.imem_wd !== exp_w) begin n_fail++;
                    $display("FAIL rnd_write i=%0d got we=%0b addr=%0d wd=%h exp we=1 addr=%0d wd=%h", i, ifa.imem_we, ifa.imem_addr, ifa.imem_wd, m_addr, exp_w); end
                stall = $urandom_range(0, 3);
                for (int s = 0; s < stall; s++) begin
                    ifa.mem_ready = 1'b0;
                    tick();
                    n_cmp++; if (ifa.imem_we !== 1'b1 || ifa.imem_wd !== exp_w || ifa.in_ready !== 1'b0) begin n_fail++;
                        $display("FAIL rnd_stall i=%0d got we=%0b wd=%h ready=%0b exp we=1 wd=%h ready=0", i, ifa.imem_we, ifa.imem_wd, ifa.in_ready, exp_w); end
                end
                ifa.mem_ready = 1'b1;
                tick();
                ifa.mem_ready = 1'b0;
                m_addr++; m_count++;
                n_cmp++; if (ifa.imem_we !== 1'b0 || ifa.wr_count !== 7'(m_count) || ifa.imem_addr !== 6'(m_addr)) begin n_fail++;
                    $display("FAIL rnd_commit i=%0d got we=%0b cnt=%0d addr=%0d exp we=0 cnt=%0d addr=%0d", i, ifa.imem_we, ifa.wr_count, ifa.imem_addr, m_count, m_addr); end
            end else begin
                if (!m_err) m_code = code;
                m_err = 1'b1;
                n_cmp++; if (ifa.imem_we !== 1'b0 || ifa.err !== 1'b1 || ifa.err_code !== 2'(m_code) || ifa.wr_count !== 7'(m_count)) begin n_fail++;
                    $display("FAIL rnd_reject i=%0d got we=%0b err=%0b code=%0d cnt=%0d exp we=0 err=1 code=%0d cnt=%0d", i, ifa.imem_we, ifa.err, ifa.err_code, ifa.wr_count, m_code, m_count); end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        drive_a(14, 0, 6'b101000, 2, 1, 12'h005, 0, 1'b0);
        ifa.mem_ready = 1'b0;
        tick();
        ifa.in_valid = 1'b0;
        n_cmp++; if (ifa.imem_we !== 1'b1) begin n_fail++; $display("FAIL mid_we got=%0b exp=1", ifa.imem_we); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (ifa.imem_we !== 1'b0 || ifa.wr_count !== 7'd0 || ifa.imem_addr !== 6'd0 || ifa.in_ready !== 1'b1 || ifa.err !== 1'b0) begin n_fail++;
            $display("FAIL mid_reset got we=%0b cnt=%0d addr=%0d ready=%0b err=%0b exp 0 0 0 1 0", ifa.imem_we, ifa.wr_count, ifa.imem_addr, ifa.in_ready, ifa.err); end
    endtask

    task automatic test_errors();
        int fn[3] = '{6'b000010, 6'b010100, 6'b101000};
        int op[3] = '{0, 0, 3};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive_a(14, op[k], fn[k], 1, 2, 12'h0AB, 0, 1'b0);
            ifa.mem_ready = 1'b1;
            tick();
            ifa.in_valid = 1'b0;
            n_cmp++; if (ifa.imem_we !== 1'b0 || ifa.err !== 1'b1 || ifa.err_code !== 2'b10 || ifa.wr_count !== 7'd0) begin n_fail++;
                $display("FAIL err_seq k=%0d got we=%0b err=%0b code=%b cnt=%0d exp we=0 err=1 code=10 cnt=0", k, ifa.imem_we, ifa.err, ifa.err_code, ifa.wr_count); end
            n_cmp++; if (ifa.in_ready !== 1'b1 || ifa.done !== 1'b0) begin n_fail++;
                $display("FAIL err_ready k=%0d got ready=%0b done=%0b exp ready=1 done=0", k, ifa.in_ready, ifa.done); end
        end
        ifa.mem_ready = 1'b0;
    endtask

    task automatic test_branch_done();
        do_reset();
        drive_a(14, 2, 6'b101010, 0, 0, 0, 24'h000002, 1'b1);
        ifa.mem_ready = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
        n_cmp++; if (ifa.imem_we !== 1'b1 || ifa.imem_wd !== 32'hEA00_0002) begin n_fail++;
            $display("FAIL b_wd got we=%0b wd=%h exp we=1 wd=EA000002", ifa.imem_we, ifa.imem_wd); end
        n_cmp++; if (ifa.done !== 1'b0) begin n_fail++; $display("FAIL b_done_early got=%0b exp=0", ifa.done); end
        tick();
        n_cmp++; if (ifa.done !== 1'b1 || ifa.in_ready !== 1'b0 || ifa.wr_count !== 7'd1) begin n_fail++;
            $display("FAIL b_done got done=%0b ready=%0b cnt=%0d exp done=1 ready=0 cnt=1", ifa.done, ifa.in_ready, ifa.wr_count); end
        drive_a(14, 0, 6'b101000, 2, 1, 12'h005, 0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (ifa.imem_we !== 1'b0 || ifa.err !== 1'b0 || ifa.wr_count !== 7'd1 || ifa.in_ready !== 1'b0) begin n_fail++;
                $display("FAIL b_ignore c=%0d got we=%0b err=%0b cnt=%0d ready=%0b exp 0 0 1 0", c, ifa.imem_we, ifa.err, ifa.wr_count, ifa.in_ready); end
        end
        ifa.in_valid = 1'b0;
        ifa.mem_ready = 1'b0;
        do_reset();
        drive_a(14, 3, 6'b000000, 0, 0, 0, 0, 1'b1);
        tick();
        ifa.in_valid = 1'b0;
        n_cmp++; if (ifa.done !== 1'b1 || ifa.err !== 1'b1 || ifa.err_code !== 2'b01 || ifa.imem_we !== 1'b0) begin n_fail++;
            $display("FAIL ill_last got done=%0b err=%0b code=%b we=%0b exp done=1 err=1 code=01 we=0", ifa.done, ifa.err, ifa.err_code, ifa.imem_we); end
    endtask

    task automatic test_full();
        do_reset();
        ifb.in_cond = 4'hE; ifb.in_op = 2'b00; ifb.in_funct = 6'b101000; ifb.in_rn = 4'd2;
        ifb.in_src2 = 12'h005; ifb.in_imm24 = 24'h000000; ifb.in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifb.in_rd = 4'(i);
            ifb.in_valid = 1'b1;
            ifb.mem_ready = 1'b1;
            tick();
            ifb.in_valid = 1'b0;
            n_cmp++; if (ifb.imem_we !== 1'b1 || ifb.imem_addr !== 2'(i) || ifb.imem_wd !== ref_word(14, 0, 40, 2, i, 5, 0)) begin n_fail++;
                $display("FAIL full_wr i=%0d got we=%0b addr=%0d wd=%h exp we=1 addr=%0d", i, ifb.imem_we, ifb.imem_addr, ifb.imem_wd, i); end
            tick();
        end
        ifb.mem_ready = 1'b0;
        n_cmp++; if (ifb.full !== 1'b1 || ifb.imem_addr !== 2'd0 || ifb.wr_count !== 3'd4 || ifb.in_ready !== 1'b0) begin n_fail++;
            $display("FAIL full_state got full=%0b addr=%0d cnt=%0d ready=%0b exp full=1 addr=0 cnt=4 ready=0", ifb.full, ifb.imem_addr, ifb.wr_count, ifb.in_ready); end
        ifb.in_valid = 1'b1;
        tick();
        ifb.in_valid = 1'b0;
        n_cmp++; if (ifb.err !== 1'b1 || ifb.err_code !== 2'b11 || ifb.imem_we !== 1'b0 || ifb.wr_count !== 3'd4) begin n_fail++;
            $display("FAIL full_drop got err=%0b code=%b we=%0b cnt=%0d exp err=1 code=11 we=0 cnt=4", ifb.err, ifb.err_code, ifb.imem_we, ifb.wr_count); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; reset = 1'b1; n_cmp = 0; n_fail = 0;
        ifa.in_valid = 1'b0; ifa.in_last = 1'b0; ifa.mem_ready = 1'b0;
        ifa.in_cond = 4'h0; ifa.in_op = 2'b00; ifa.in_funct = 6'h00; ifa.in_rn = 4'h0;
        ifa.in_rd = 4'h0; ifa.in_src2 = 12'h000; ifa.in_imm24 = 24'h000000;
        ifb.in_valid = 1'b0; ifb.in_last = 1'b0; ifb.mem_ready = 1'b0;
        ifb.in_cond = 4'h0; ifb.in_op = 2'b00; ifb.in_funct = 6'h00; ifb.in_rn = 4'h0;
        ifb.in_rd = 4'h0; ifb.in_src2 = 12'h000; ifb.in_imm24 = 24'h000000;
        test_reset();
        test_dp_add();
        test_ldr_stall();
        test_random();
        test_reset_mid_write();
        test_errors();
        test_branch_done();
        test_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
